// File: rtl/fifo_rd_stream.sv
// Read-side consumer: pops the async FIFO head into a 2-deep skid and streams bounded bursts on valid/ready.
// Latency: one cycle from rinc to m_valid when the buffer is empty; one word per cycle sustained.
// Backpressure: m_ready only affects buffer occupancy; rinc stops at occ==2. Optional RD_STATS_EN adds stall_cnt.
module fifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 24
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rempty,
    output logic              rinc,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  xfer_cnt
`ifdef RD_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  fetch_left;
    logic [1:0]        occ;
    logic [DATA_W-1:0] head_dat;
    logic              head_last;
    logic [DATA_W-1:0] tail_dat;
    logic              tail_last;
    logic              push;
    logic              pop;
    logic              start_acc;

    assign push      = rinc;
    assign pop       = m_valid && m_ready;
    assign start_acc = (state == IDLE) && start;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? ACTIVE : DRAIN;
                end
            end
            ACTIVE: begin
                if (abort) begin
                    state_nxt = DRAIN;
                end else if (rinc && (fetch_left == LEN_ONE)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (occ == 2'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rinc depends only on registered state, rempty and abort, never on m_ready.
    always_comb begin
        rinc = (state == ACTIVE) && !abort && !rempty && (fetch_left != '0) && (occ != 2'd2);
        busy = (state != IDLE);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            done <= 1'b0;
        end else begin
            done <= (state == DRAIN) && (occ == 2'd0);
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            fetch_left <= '0;
        end else if (start_acc) begin
            fetch_left <= len;
        end else if (push) begin
            fetch_left <= fetch_left - LEN_ONE;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            xfer_cnt <= '0;
        end else if (start_acc) begin
            xfer_cnt <= '0;
        end else if (pop && (xfer_cnt != '1)) begin
            xfer_cnt <= xfer_cnt + LEN_ONE;
        end
    end

    // Head register feeds m_data directly; the tail slot only fills while the head is stalled.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            occ       <= 2'd0;
            head_dat  <= '0;
            head_last <= 1'b0;
            tail_dat  <= '0;
            tail_last <= 1'b0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        head_dat  <= rdata;
                        head_last <= (fetch_left == LEN_ONE);
                        occ       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_dat  <= rdata;
                        head_last <= (fetch_left == LEN_ONE);
                    end else if (push) begin
                        tail_dat  <= rdata;
                        tail_last <= (fetch_left == LEN_ONE);
                        occ       <= 2'd2;
                    end else if (pop) begin
                        occ       <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_dat  <= tail_dat;
                        head_last <= tail_last;
                        occ       <= 2'd1;
                    end
                end
                default: occ <= 2'd0;
            endcase
        end
    end

    assign m_valid = (occ != 2'd0);
    assign m_data  = head_dat;
    assign m_last  = head_last && m_valid;

`ifdef RD_STATS_EN
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if ((state == ACTIVE) && rempty && (fetch_left != '0) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream: a queue-based FIFO environment plus a transaction-level reference model.
module tb_fifo_rd_stream;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 24;

    logic              rclk = 1'b0;
    logic              rrst;
    logic [DATA_W-1:0] rdata;
    logic              rempty;
    logic              rinc;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  xfer_cnt;
`ifdef RD_STATS_EN
    logic [15:0]       stall_cnt;
`endif

    fifo_rd_stream #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rdata    (rdata),
        .rempty   (rempty),
        .rinc     (rinc),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done),
        .xfer_cnt (xfer_cnt)
`ifdef RD_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
    } ent_t;

    // Environment: the FIFO contents as seen by the read port.
    logic [DATA_W-1:0] fifo[$];
    logic [DATA_W-1:0] got[$];
    int                npop;

    // Reference model: burst phase (0 idle, 1 fetching, 2 draining), words still to fetch, words held.
    ent_t mbuf[$];
    int   phase;
    int   remaining;
    int   xfer;
    int   stall;
    bit   exp_done;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mbuf.delete();
        phase     = 0;
        remaining = 0;
        xfer      = 0;
        stall     = 0;
        exp_done  = 0;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        bit   ep;
        bit   acc;
        ent_t e;
        rempty = (fifo.size() == 0);
        rdata  = rempty ? '0 : fifo[0];
        #1;
        ep = (phase == 1) && !abort && !rempty && (remaining != 0) && (mbuf.size() < 2);
        chk("rinc", rinc, ep);
        chk("m_valid", m_valid, mbuf.size() != 0);
        if (mbuf.size() != 0) begin
            chk("m_data", m_data, mbuf[0].d);
            chk("m_last", m_last, mbuf[0].l);
        end
        chk("busy", busy, phase != 0);
        chk("done", done, exp_done);
        chk("xfer_cnt", xfer_cnt, xfer);
`ifdef RD_STATS_EN
        chk("stall_cnt", stall_cnt, stall);
`endif
        if (rinc) npop++;
        if (m_valid && m_ready) got.push_back(m_data);

        acc      = (mbuf.size() != 0) && m_ready;
        exp_done = 0;
        if (phase == 1 && rempty && remaining != 0 && stall < 65535) stall++;
        case (phase)
            0: if (start) begin
                remaining = len;
                xfer      = 0;
                stall     = 0;
                phase     = (len != 0) ? 1 : 2;
            end
            1: if (abort || (ep && remaining == 1)) phase = 2;
            default: if (mbuf.size() == 0) begin
                phase    = 0;
                exp_done = 1;
            end
        endcase
        if (acc) begin
            void'(mbuf.pop_front());
            if (xfer < (1 << LEN_W) - 1) xfer++;
        end
        if (ep) begin
            e.d = fifo[0];
            e.l = (remaining == 1);
            mbuf.push_back(e);
            remaining--;
        end
        if (rinc && fifo.size() != 0) void'(fifo.pop_front());
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic kick(input int n);
        len   = LEN_W'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic finish_burst(input int budget);
        for (int i = 0; i < budget && (phase != 0 || exp_done); i++) step();
        if (phase != 0) chk("burst_timeout", busy, 0);
    endtask

    task automatic begin_case();
        got.delete();
        npop = 0;
    endtask

    initial begin
        rrst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; m_ready = 1'b0;
        rdata = '0; rempty = 1'b1; npop = 0;
        model_reset();
        @(negedge rclk);
        #1;
        chk("rst_rinc", rinc, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_xfer", xfer_cnt, 0);
        @(negedge rclk);
        rrst = 1'b0;
        step();

        // Full-rate burst of four preloaded words; a start mid-burst must be ignored.
        begin_case();
        for (int i = 0; i < 4; i++) fifo.push_back(8'h11 + 8'(i));
        m_ready = 1'b1;
        kick(4);
        step();
        start = 1'b1; len = LEN_W'(7);
        step();
        start = 1'b0;
        finish_burst(50);
        chk("s1_pops", npop, 4);
        chk("s1_count", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("s1_word", got[i], 8'h11 + 8'(i));
        chk("s1_xfer", xfer_cnt, 4);

        // Same burst with downstream stalled for five cycles.
        begin_case();
        for (int i = 0; i < 4; i++) fifo.push_back(8'h11 + 8'(i));
        m_ready = 1'b0;
        kick(4);
        repeat (4) step();
        chk("s2_pops_stalled", npop, 2);
        m_ready = 1'b1;
        finish_burst(50);
        chk("s2_count", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("s2_word", got[i], 8'h11 + 8'(i));

        // Starved FIFO: one word every fourth cycle.
        begin_case();
        kick(3);
        for (int i = 0; i < 60 && (phase != 0 || exp_done); i++) begin
            if (i % 4 == 3) fifo.push_back(8'hA0 + 8'(i));
            step();
        end
        chk("s3_pops", npop, 3);
        chk("s3_xfer", xfer_cnt, 3);

        // Abort after two pops with the buffer full.
        begin_case();
        fifo.delete();
        for (int i = 0; i < 10; i++) fifo.push_back(8'h20 + 8'(i));
        m_ready = 1'b0;
        kick(10);
        for (int i = 0; i < 10 && npop < 2; i++) step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        m_ready = 1'b1;
        finish_burst(50);
        chk("s4_pops", npop, 2);
        chk("s4_left", fifo.size(), 8);
        chk("s4_xfer", xfer_cnt, 2);

        // Zero-length burst: one DRAIN cycle then done.
        begin_case();
        fifo.delete();
        fifo.push_back(8'h55);
        kick(0);
        chk("s5_busy", busy, 1);
        step();
        chk("s5_done", done, 1);
        step();
        chk("s5_pops", npop, 0);

        // Randomized bursts with random backpressure, FIFO refill and aborts.
        fifo.delete();
        for (int c = 0; c < 2000; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            abort   = (phase == 1) && ($urandom_range(0, 40) == 0);
            start   = ($urandom_range(0, 3) == 0);
            len     = LEN_W'($urandom_range(0, 12));
            if (fifo.size() < 16 && $urandom_range(0, 2) != 0) fifo.push_back(8'($urandom));
            step();
        end
        start = 1'b0; abort = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 400 && phase != 0; i++) begin
            fifo.push_back(8'($urandom));
            step();
        end
        finish_burst(10);

        // Asynchronous reset in the middle of a stalled burst.
        begin_case();
        fifo.delete();
        for (int i = 0; i < 6; i++) fifo.push_back(8'h30 + 8'(i));
        m_ready = 1'b0;
        kick(6);
        repeat (3) step();
        #2 rrst = 1'b1;
        #1;
        chk("arst_rinc", rinc, 0);
        chk("arst_m_valid", m_valid, 0);
        chk("arst_busy", busy, 0);
        model_reset();
        fifo.delete();
        @(negedge rclk);
        rrst = 1'b0;
        step();
        chk("arst_xfer", xfer_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side consumer for the async FIFO read port: drives rinc, captures the combinational rdata head word and honours rempty.
- Delivers words as length-bounded bursts on a valid/ready stream, through a 2-entry holding buffer.
- Sits entirely in the read clock domain, between the read block and downstream logic.
- Gives full throughput (one word/cycle) with no combinational path from m_ready to rinc.

Parameters:
DATA_W, 8, FIFO word width (matches FIFO memory width)
LEN_W, 24, burst length / counter width (one bit wider than the 23-bit FIFO address)

Ports:
rclk  in  1  read-domain clock; all logic on posedge
rrst  in  1  asynchronous, active-high reset (asserts immediately, released synchronously by the top level)
rdata  in  DATA_W  FIFO head word; combinational, valid whenever rempty=0
rempty  in  1  FIFO empty flag (registered in the read block)
rinc  out  1  pop request to the FIFO read block
start  in  1  one-cycle burst request, sampled only in IDLE
len  in  LEN_W  word count for the burst, sampled with start
abort  in  1  stop fetching; drain the buffer and end the burst
m_valid  out  1  stream data valid
m_ready  in  1  downstream accept
m_data  out  DATA_W  stream data
m_last  out  1  marks the final word of a non-aborted burst
busy  out  1  FSM not in IDLE
done  out  1  one-cycle burst-complete pulse
xfer_cnt  out  LEN_W  words delivered (m_valid&&m_ready) in the current/last burst

Behaviour:
- Reset (rrst=1, async): FSM=IDLE, buffer occupancy occ=0, fetch_left=0, xfer_cnt=0; rinc=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. Reset mid-burst discards buffered words; rinc drops immediately.
- FSM states: IDLE, ACTIVE, DRAIN.
  - IDLE, start=1: load fetch_left=len, clear xfer_cnt; go to ACTIVE if len!=0, else DRAIN.
  - ACTIVE: on abort, go to DRAIN. Also go to DRAIN on the edge where the final pop brings fetch_left to 0.
  - DRAIN: when occ==0, go to IDLE; done=1 for exactly the first cycle back in IDLE.
  - start is ignored outside IDLE. abort is ignored outside ACTIVE.
- rinc = (state==ACTIVE) && !abort && !rempty && fetch_left!=0 && occ<2. Purely from registered state plus rempty/abort; independent of m_ready.
- Pop (rinc=1): at the edge, rdata is written into the buffer tail with tag last=(fetch_left==1), and fetch_left decrements.
- Latency: rinc at cycle N gives the word on m_data with m_valid=1 at cycle N+1, when the buffer was empty.
- Buffer: 2-entry FIFO with registered head driving m_data/m_valid/m_last.
  - m_valid = occ!=0; m_last = head tag and m_valid.
  - Simultaneous push and pop leaves occ unchanged (occ=1 steady state gives 1 word/cycle).
  - m_data/m_last are held stable while m_valid&&!m_ready.
- Empty FIFO during ACTIVE: rinc=0 and the burst simply stalls; no timeout.
- abort: no further rinc from the abort cycle onward. Already-buffered words are still delivered. m_last is not asserted for an aborted burst. The done pulse still occurs.
- xfer_cnt increments on each m_valid&&m_ready and saturates at all-ones. It is held after done until the next accepted start.
- busy = state!=IDLE.

Optional Feature:
RD_STATS_EN
- Defined: adds output stall_cnt [15:0]. It counts cycles in ACTIVE with rempty=1 and fetch_left!=0, saturates at 16'hFFFF, and clears on an accepted start and on reset.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-burst: set rrst=1 while ACTIVE with occ=2 -> same cycle rinc=0, m_valid=0, busy=0; after release, state IDLE and xfer_cnt=0.
- FIFO preloaded 0x11..0x14, start len=4, m_ready=1 -> 4 consecutive rinc cycles; m_data 0x11,0x12,0x13,0x14 on consecutive cycles starting 1 cycle after first rinc; m_last only on 0x14; done 1 cycle after last transfer; xfer_cnt=4.
- Same burst with m_ready=0 for 5 cycles -> rinc exactly 2 cycles, then 0 while occ=2; m_data holds 0x11; resuming m_ready delivers all 4 in order with no loss or duplication.
- start len=3, FIFO empty, then write one word every 4 write cycles -> rinc only when rempty=0; burst completes after 3 words. With RD_STATS_EN, stall_cnt equals the counted empty cycles.
- start len=10 with abort asserted after 2 pops, occ=2 -> no rinc from abort cycle; 2 words delivered, m_last=0 throughout; done pulses; xfer_cnt=2; FIFO keeps remaining 8 words.
- start len=0 -> no rinc; busy=1 for 1 cycle (DRAIN), done pulses next cycle. start asserted while busy -> ignored, fetch_left unchanged.
